// File: rtl/instr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// instr_mem_ctrl
//
// Slave side of the in-order instruction interface (req/gnt/valid). Each
// granted fetch is served from a single-port synchronous SRAM with one cycle
// of read latency. A fixed number of wait states can be added to every
// response to model slower program memory. Fetches that fall outside the
// SRAM window or are not word aligned do not touch the SRAM and answer with
// a bus error.
//
// Because every response takes exactly 1+WAIT_STATES cycles, responses come
// back in grant order without any reorder logic. The outstanding counter
// only throttles grants so that no more than MAX_OUTSTANDING requests are in
// flight at any time.
//
// Parameters:
//   ADDR_BASE        byte address of SRAM word 0 (word aligned)
//   MEM_DEPTH_WORDS  SRAM depth in 32-bit words (power of 2)
//   WAIT_STATES      extra response cycles, 0..7
//   MAX_OUTSTANDING  granted-but-unanswered requests allowed, 1..8
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   instr_req    in   fetch request
//   instr_addr   in   fetch byte address (stable until granted)
//   instr_gnt    out  request accepted this cycle (combinational)
//   instr_valid  out  one response pulse per grant
//   instr_rdata  out  response data, 0 on error or when not valid
//   instr_err    out  response is a bus error, qualified by instr_valid
//   sram_ce      out  SRAM read enable
//   sram_addr    out  SRAM word address
//   sram_rdata   in   SRAM read data, valid the cycle after sram_ce
// ---------------------------------------------------------------------------
module instr_mem_ctrl #(
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int          MEM_DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES     = 0,
    parameter int          MAX_OUTSTANDING = 2,
    localparam int         AW              = $clog2(MEM_DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          instr_req,
    input  logic [31:0]   instr_addr,
    output logic          instr_gnt,
    output logic          instr_valid,
    output logic [31:0]   instr_rdata,
    output logic          instr_err,
    output logic          sram_ce,
    output logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_rdata
);

    localparam int             OCW       = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OCW-1:0] OC_MAX    = OCW'(MAX_OUTSTANDING);
    localparam logic [31:0]    MEM_BYTES = 32'(MEM_DEPTH_WORDS * 4);

    logic [31:0]    offset;
    logic           in_range;
    logic           misaligned;
    logic           req_ok;
    logic           room;
    logic [OCW-1:0] oc;

    // Request decode. Addresses below ADDR_BASE wrap to a large offset and
    // therefore fall out of range without a separate lower-bound compare.
    assign offset     = instr_addr - ADDR_BASE;
    assign in_range   = offset < MEM_BYTES;
    assign misaligned = instr_addr[1:0] != 2'b00;
    assign req_ok     = in_range & ~misaligned;

    // A response leaving this cycle frees a slot, so a full counter still
    // allows a grant when instr_valid is high.
    assign room      = oc < OC_MAX;
    assign instr_gnt = reset_n & instr_req & (room | instr_valid);
    assign sram_ce   = instr_gnt & req_ok;
    assign sram_addr = offset[AW+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oc <= '0;
        end else begin
            case ({instr_gnt, instr_valid})
                2'b10:   oc <= oc + OCW'(1);
                2'b01:   oc <= oc - OCW'(1);
                default: oc <= oc;
            endcase
        end
    end

    // Stage 0: response tag captured at the grant edge
    logic vld_p0;
    logic err_p0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            err_p0 <= 1'b0;
        end else begin
            vld_p0 <= instr_gnt;
            err_p0 <= instr_gnt & ~req_ok;
        end
    end

    generate
        if (WAIT_STATES == 0) begin : g_direct
            // SRAM data is on sram_rdata while the stage-0 tag is valid
            assign instr_valid = vld_p0;
            assign instr_err   = vld_p0 & err_p0;
            assign instr_rdata = (vld_p0 & ~err_p0) ? sram_rdata : 32'h0;
        end else begin : g_delay
            logic        vld_pipe  [WAIT_STATES];
            logic        err_pipe  [WAIT_STATES];
            logic [31:0] data_pipe [WAIT_STATES];

            // Wait-state stages: control
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < WAIT_STATES; i++) begin
                        vld_pipe[i] <= 1'b0;
                        err_pipe[i] <= 1'b0;
                    end
                end else begin
                    vld_pipe[0] <= vld_p0;
                    err_pipe[0] <= err_p0;
                    for (int i = 1; i < WAIT_STATES; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        err_pipe[i] <= err_pipe[i-1];
                    end
                end
            end

            // Wait-state stages: data. SRAM data is only live for one cycle,
            // so it is captured (or forced to 0 for errors) on leaving
            // stage 0.
            always_ff @(posedge clk) begin
                data_pipe[0] <= (vld_p0 & ~err_p0) ? sram_rdata : 32'h0;
                for (int i = 1; i < WAIT_STATES; i++) begin
                    data_pipe[i] <= data_pipe[i-1];
                end
            end

            // Data registers are not reset; gating by valid keeps the
            // output at 0 outside of a response.
            assign instr_valid = vld_pipe[WAIT_STATES-1];
            assign instr_err   = vld_pipe[WAIT_STATES-1] & err_pipe[WAIT_STATES-1];
            assign instr_rdata = vld_pipe[WAIT_STATES-1] ? data_pipe[WAIT_STATES-1] : 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_ctrl.sv
module tb_instr_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [31:0] addr;

    logic        gnt   [4];
    logic        vld   [4];
    logic        err   [4];
    logic        ce    [4];
    logic [31:0] rdata [4];
    logic [31:0] srd   [4];
    logic [11:0] saddr [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instances with different latency settings share the request inputs;
    // each test looks at one of them and resets all of them beforehand.
    instr_mem_ctrl #(.WAIT_STATES(0), .MAX_OUTSTANDING(2)) u_ws0 (
        .clk(clk), .reset_n(reset_n), .instr_req(req), .instr_addr(addr),
        .instr_gnt(gnt[0]), .instr_valid(vld[0]), .instr_rdata(rdata[0]),
        .instr_err(err[0]), .sram_ce(ce[0]), .sram_addr(saddr[0]), .sram_rdata(srd[0]));
    instr_mem_ctrl #(.WAIT_STATES(1), .MAX_OUTSTANDING(2)) u_ws1 (
        .clk(clk), .reset_n(reset_n), .instr_req(req), .instr_addr(addr),
        .instr_gnt(gnt[1]), .instr_valid(vld[1]), .instr_rdata(rdata[1]),
        .instr_err(err[1]), .sram_ce(ce[1]), .sram_addr(saddr[1]), .sram_rdata(srd[1]));
    instr_mem_ctrl #(.WAIT_STATES(2), .MAX_OUTSTANDING(2)) u_ws2 (
        .clk(clk), .reset_n(reset_n), .instr_req(req), .instr_addr(addr),
        .instr_gnt(gnt[2]), .instr_valid(vld[2]), .instr_rdata(rdata[2]),
        .instr_err(err[2]), .sram_ce(ce[2]), .sram_addr(saddr[2]), .sram_rdata(srd[2]));
    instr_mem_ctrl #(.WAIT_STATES(3), .MAX_OUTSTANDING(4)) u_ws3 (
        .clk(clk), .reset_n(reset_n), .instr_req(req), .instr_addr(addr),
        .instr_gnt(gnt[3]), .instr_valid(vld[3]), .instr_rdata(rdata[3]),
        .instr_err(err[3]), .sram_ce(ce[3]), .sram_addr(saddr[3]), .sram_rdata(srd[3]));

    // SRAM contents: word 0 = 0x413, word n = 0xC0DE_0000 + n
    function automatic logic [31:0] mem_word(input logic [11:0] w);
        return (w == 12'd0) ? 32'h0000_0413 : (32'hC0DE_0000 | {20'h0, w});
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ce[k]) srd[k] <= mem_word(saddr[k]);
        end
    end

    // Hand-computed SRAM words 0..8
    logic [31:0] exp_w [9] = '{32'h0000_0413, 32'hC0DE_0001, 32'hC0DE_0002,
                               32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0005,
                               32'hC0DE_0006, 32'hC0DE_0007, 32'hC0DE_0008};

    // Fetch-stage model: records what instance k does each cycle
    logic [31:0] pend     [$];
    int          gnt_cyc  [$];
    int          vld_cyc  [$];
    logic [31:0] vld_data [$];
    logic        vld_err  [$];
    logic        ce_rec   [$];
    logic [11:0] sa_rec   [$];
    int          max_oc;
    int          idle_bad;

    task automatic run(input int k, input int ncyc);
        int   oc_m;
        logic g;
        logic v;
        gnt_cyc.delete(); vld_cyc.delete(); vld_data.delete();
        vld_err.delete(); ce_rec.delete(); sa_rec.delete();
        oc_m = 0; max_oc = 0; idle_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (pend.size() > 0) begin
                req = 1'b1; addr = pend[0];
            end else begin
                req = 1'b0; addr = 32'h0;
            end
            #1;
            g = gnt[k];
            v = vld[k];
            if (g) begin
                gnt_cyc.push_back(c);
                ce_rec.push_back(ce[k]);
                sa_rec.push_back(saddr[k]);
                void'(pend.pop_front());
            end
            if (v) begin
                vld_cyc.push_back(c);
                vld_data.push_back(rdata[k]);
                vld_err.push_back(err[k]);
            end else if (rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
                idle_bad++;
            end
            if (g && !v) oc_m++;
            else if (!g && v) oc_m--;
            if (oc_m > max_oc) max_oc = oc_m;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; req = 1'b0; addr = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 1'b1; addr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (gnt[k] !== 1'b0) begin errors++; $display("FAIL reset_gnt[%0d]: got %b want 0", k, gnt[k]); end
            checks++; if (vld[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", k, vld[k]); end
            checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
            checks++; if (rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata[k]); end
            checks++; if (ce[k] !== 1'b0) begin errors++; $display("FAIL reset_ce[%0d]: got %b want 0", k, ce[k]); end
        end
    endtask

    task automatic test_single();
        // Request in the very first cycle after release
        @(negedge clk);
        reset_n = 1'b1; req = 1'b1; addr = 32'h0;
        #1;
        checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", gnt[0]); end
        checks++; if (ce[0] !== 1'b1) begin errors++; $display("FAIL single_ce: got %b want 1", ce[0]); end
        checks++; if (saddr[0] !== 12'h0) begin errors++; $display("FAIL single_saddr: got %h want 0", saddr[0]); end
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", vld[0]); end
        @(negedge clk);
        req = 1'b0;
        #1;
        checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", vld[0]); end
        checks++; if (rdata[0] !== 32'h0000_0413) begin errors++; $display("FAIL single_rdata: got %h want 00000413", rdata[0]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err[0]); end
        @(negedge clk);
        #1;
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b want 0", vld[0]); end
        checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL single_rdata_after: got %h want 0", rdata[0]); end
    endtask

    task automatic test_stream();
        int gc;
        int vc;
        apply_reset();
        pend = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        run(0, 12);
        checks++; if (gnt_cyc.size() !== 8) begin errors++; $display("FAIL stream_gnt_count: got %0d want 8", gnt_cyc.size()); end
        checks++; if (vld_cyc.size() !== 8) begin errors++; $display("FAIL stream_valid_count: got %0d want 8", vld_cyc.size()); end
        for (int i = 0; i < 8; i++) begin
            gc = (i < gnt_cyc.size()) ? gnt_cyc[i] : -1;
            vc = (i < vld_cyc.size()) ? vld_cyc[i] : -1;
            checks++; if (gc !== i) begin errors++; $display("FAIL stream_gnt_cycle[%0d]: got %0d want %0d", i, gc, i); end
            checks++; if (vc !== i + 1) begin errors++; $display("FAIL stream_valid_cycle[%0d]: got %0d want %0d", i, vc, i + 1); end
            if (i < vld_cyc.size()) begin
                checks++; if (vld_data[i] !== exp_w[i]) begin errors++; $display("FAIL stream_rdata[%0d]: got %h want %h", i, vld_data[i], exp_w[i]); end
                checks++; if (vld_err[i] !== 1'b0) begin errors++; $display("FAIL stream_err[%0d]: got %b want 0", i, vld_err[i]); end
            end
        end
        checks++; if (max_oc > 1) begin errors++; $display("FAIL stream_max_outstanding: got %0d want <=1", max_oc); end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL stream_idle_outputs: got %0d nonzero idle cycles want 0", idle_bad); end
    endtask

    task automatic test_throttle();
        int exp_g [6] = '{0, 1, 3, 4, 6, 7};
        int exp_v [6] = '{3, 4, 6, 7, 9, 10};
        int gc;
        int vc;
        apply_reset();
        pend = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        run(2, 14);
        checks++; if (gnt_cyc.size() !== 6) begin errors++; $display("FAIL throttle_gnt_count: got %0d want 6", gnt_cyc.size()); end
        for (int i = 0; i < 6; i++) begin
            gc = (i < gnt_cyc.size()) ? gnt_cyc[i] : -1;
            vc = (i < vld_cyc.size()) ? vld_cyc[i] : -1;
            checks++; if (gc !== exp_g[i]) begin errors++; $display("FAIL throttle_gnt_cycle[%0d]: got %0d want %0d", i, gc, exp_g[i]); end
            checks++; if (vc !== exp_v[i]) begin errors++; $display("FAIL throttle_valid_cycle[%0d]: got %0d want %0d", i, vc, exp_v[i]); end
            if (i < vld_cyc.size()) begin
                checks++; if (vld_data[i] !== exp_w[i]) begin errors++; $display("FAIL throttle_rdata[%0d]: got %h want %h", i, vld_data[i], exp_w[i]); end
            end
        end
        checks++; if (max_oc > 2) begin errors++; $display("FAIL throttle_max_outstanding: got %0d want <=2", max_oc); end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL throttle_idle_outputs: got %0d want 0", idle_bad); end
    endtask

    task automatic test_error();
        logic        exp_ce  [3] = '{1'b0, 1'b0, 1'b1};
        logic        exp_e   [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exp_d   [3] = '{32'h0, 32'h0, 32'hC0DE_0004};
        apply_reset();
        pend = '{32'h0000_4000, 32'h0000_0002, 32'h0000_0010};
        run(0, 6);
        checks++; if (gnt_cyc.size() !== 3) begin errors++; $display("FAIL error_gnt_count: got %0d want 3", gnt_cyc.size()); end
        checks++; if (vld_cyc.size() !== 3) begin errors++; $display("FAIL error_valid_count: got %0d want 3", vld_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < ce_rec.size()) begin
                checks++; if (ce_rec[i] !== exp_ce[i]) begin errors++; $display("FAIL error_ce[%0d]: got %b want %b", i, ce_rec[i], exp_ce[i]); end
            end
            if (i < vld_cyc.size()) begin
                checks++; if (vld_err[i] !== exp_e[i]) begin errors++; $display("FAIL error_err[%0d]: got %b want %b", i, vld_err[i], exp_e[i]); end
                checks++; if (vld_data[i] !== exp_d[i]) begin errors++; $display("FAIL error_rdata[%0d]: got %h want %h", i, vld_data[i], exp_d[i]); end
                checks++; if (vld_cyc[i] !== i + 1) begin errors++; $display("FAIL error_valid_cycle[%0d]: got %0d want %0d", i, vld_cyc[i], i + 1); end
            end
        end
        if (sa_rec.size() > 2) begin
            checks++; if (sa_rec[2] !== 12'd4) begin errors++; $display("FAIL error_saddr: got %h want 004", sa_rec[2]); end
        end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL error_idle_outputs: got %0d want 0", idle_bad); end
    endtask

    task automatic test_mixed();
        logic        exp_ce [3] = '{1'b1, 1'b0, 1'b1};
        logic        exp_e  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exp_d  [3] = '{32'hC0DE_0002, 32'h0, 32'hC0DE_0003};
        apply_reset();
        pend = '{32'h0000_0008, 32'h8000_0000, 32'h0000_000C};
        run(1, 7);
        checks++; if (vld_cyc.size() !== 3) begin errors++; $display("FAIL mixed_valid_count: got %0d want 3", vld_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < ce_rec.size()) begin
                checks++; if (ce_rec[i] !== exp_ce[i]) begin errors++; $display("FAIL mixed_ce[%0d]: got %b want %b", i, ce_rec[i], exp_ce[i]); end
                checks++; if (gnt_cyc[i] !== i) begin errors++; $display("FAIL mixed_gnt_cycle[%0d]: got %0d want %0d", i, gnt_cyc[i], i); end
            end
            if (i < vld_cyc.size()) begin
                checks++; if (vld_cyc[i] !== i + 2) begin errors++; $display("FAIL mixed_valid_cycle[%0d]: got %0d want %0d", i, vld_cyc[i], i + 2); end
                checks++; if (vld_err[i] !== exp_e[i]) begin errors++; $display("FAIL mixed_err[%0d]: got %b want %b", i, vld_err[i], exp_e[i]); end
                checks++; if (vld_data[i] !== exp_d[i]) begin errors++; $display("FAIL mixed_rdata[%0d]: got %h want %h", i, vld_data[i], exp_d[i]); end
            end
        end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL mixed_idle_outputs: got %0d want 0", idle_bad); end
    endtask

    task automatic test_reset_mid();
        int gc;
        int vc;
        apply_reset();
        pend = '{32'h00, 32'h04, 32'h08};
        run(3, 4);
        checks++; if (gnt_cyc.size() !== 3) begin errors++; $display("FAIL rmid_gnt_count: got %0d want 3", gnt_cyc.size()); end
        // First response would be due in this cycle; reset must kill it
        @(negedge clk);
        reset_n = 1'b0; req = 1'b1; addr = 32'h10;
        #1;
        checks++; if (vld[3] !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", vld[3]); end
        checks++; if (gnt[3] !== 1'b0) begin errors++; $display("FAIL rmid_gnt: got %b want 0", gnt[3]); end
        checks++; if (ce[3] !== 1'b0) begin errors++; $display("FAIL rmid_ce: got %b want 0", ce[3]); end
        checks++; if (rdata[3] !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", rdata[3]); end
        checks++; if (err[3] !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", err[3]); end
        @(negedge clk);
        reset_n = 1'b1; req = 1'b0; addr = 32'h0;
        pend.delete();
        run(3, 8);
        checks++; if (vld_cyc.size() !== 0) begin errors++; $display("FAIL rmid_stale_valid: got %0d valids want 0", vld_cyc.size()); end
        // Four back-to-back grants only happen if the counter restarted at 0
        pend = '{32'h14, 32'h18, 32'h1C, 32'h20};
        run(3, 10);
        for (int i = 0; i < 4; i++) begin
            gc = (i < gnt_cyc.size()) ? gnt_cyc[i] : -1;
            vc = (i < vld_cyc.size()) ? vld_cyc[i] : -1;
            checks++; if (gc !== i) begin errors++; $display("FAIL rmid_new_gnt_cycle[%0d]: got %0d want %0d", i, gc, i); end
            checks++; if (vc !== i + 4) begin errors++; $display("FAIL rmid_new_valid_cycle[%0d]: got %0d want %0d", i, vc, i + 4); end
            if (i < vld_cyc.size()) begin
                checks++; if (vld_data[i] !== exp_w[i + 5]) begin errors++; $display("FAIL rmid_new_rdata[%0d]: got %h want %h", i, vld_data[i], exp_w[i + 5]); end
                checks++; if (vld_err[i] !== 1'b0) begin errors++; $display("FAIL rmid_new_err[%0d]: got %b want 0", i, vld_err[i]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_throttle();
        test_error();
        test_mixed();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Instruction-side memory controller that sits directly upstream of the fetch stage. It acts as the slave of the instruction interface (req/gnt/rvalid, in order) and serves each fetch from a single-port synchronous SRAM with one-cycle read latency. A configurable number of wait states models slower program memory. Out-of-range and misaligned fetches return a bus error.

## Interface
Parameters:
- ADDR_BASE, 32'h0000_0000: byte address of SRAM word 0; must be word aligned.
- MEM_DEPTH_WORDS, 4096: SRAM depth in 32-bit words; must be a power of 2; AW = log2(MEM_DEPTH_WORDS).
- WAIT_STATES, 0: extra cycles added to every response; range 0..7.
- MAX_OUTSTANDING, 2: number of granted, not-yet-answered requests allowed; range 1..8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_req  in  1  fetch request from the fetch stage.
- instr_addr  in  32  fetch byte address; held stable while instr_req is high and not granted.
- instr_gnt  out  1  request accepted this cycle.
- instr_valid  out  1  response valid; one pulse per granted request; no back-pressure.
- instr_rdata  out  32  response data, 0 when instr_err is high or instr_valid is low.
- instr_err  out  1  response is an error; qualified by instr_valid.
- sram_ce  out  1  SRAM read enable.
- sram_addr  out  AW  SRAM word address.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_ce.

## Operation
- in_range = (instr_addr - ADDR_BASE) < MEM_DEPTH_WORDS*4, computed as 32-bit unsigned; wraps below ADDR_BASE and counts as out of range.
- misaligned = instr_addr[1:0] != 2'b00.
- Outstanding counter oc (width log2(MAX_OUTSTANDING)+1):
  - +1 on instr_gnt; -1 on instr_valid; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- instr_gnt = reset_n & instr_req & (oc < MAX_OUTSTANDING | instr_valid). It is combinational and has no dependence on instr_valid beyond this term.
- sram_ce = instr_gnt & in_range & ~misaligned.
- sram_addr = (instr_addr - ADDR_BASE)[AW+1:2], driven every cycle.
- Error requests (not in_range, or misaligned): no SRAM access; the tag is {valid=1, err=1}; the response has rdata=0, err=1.
- Response pipeline:
  - Stage 0 is a tag register {valid, err} loaded at the grant edge.
  - Stage 0 is followed by WAIT_STATES registered stages of {valid, err, data}; data is captured from sram_rdata (or 0 on error) when leaving stage 0.
  - The output is the last stage. When WAIT_STATES=0, instr_rdata comes combinationally from sram_rdata, gated by err.
- Responses return in grant order; the fixed latency guarantees ordering, so no reorder logic is needed.
- There is no request cancel. Every grant produces exactly one instr_valid, including across the fetch stage's redirect.

## Timing
- Grant in cycle T: instr_valid in cycle T+1+WAIT_STATES.
- Full throughput (one grant per cycle) requires MAX_OUTSTANDING >= 1+WAIT_STATES. Otherwise grants stall while oc == MAX_OUTSTANDING and no response is returning.
- Reset values: instr_valid=0, instr_err=0, instr_rdata=0, instr_gnt=0, sram_ce=0, oc=0, all pipeline valids 0.
- Reset asserted mid-operation: all in-flight responses are discarded and none are issued after release. The fetch stage resets at the same time.
- First grant is possible in the first cycle after reset_n deasserts.
- instr_rdata and instr_err are 0 in every cycle where instr_valid=0.

## Test plan
- Single fetch, WAIT_STATES=0, SRAM word 0 = 32'h0000_0413, ADDR_BASE=0: req addr 0x0 at T -> gnt and sram_ce at T, sram_addr=0; valid at T+1 with rdata=32'h0000_0413, err=0.
- Streaming, WAIT_STATES=0, MAX_OUTSTANDING=2: req held high for addresses 0x0,0x4,...,0x1C -> 8 consecutive grants and 8 consecutive valids with words 0..7 in order; oc never exceeds 1.
- Throttle, WAIT_STATES=2, MAX_OUTSTANDING=2, req held high:
  - Grants at T and T+1; gnt=0 at T+2; gnt resumes at T+3 when the first valid returns.
  - Steady state gives 2 grants per 3 cycles.
- Error, MEM_DEPTH_WORDS=4096: fetch 0x0000_4000 (one past end), then 0x0000_0002 (misaligned) -> sram_ce=0 for both; two valids with err=1, rdata=0; a following in-range fetch returns err=0.
- Mixed ordering, WAIT_STATES=1: grant sequence good 0x8, bad 0x8000_0000, good 0xC -> valids in the same order with err 0,1,0 and correct data.
- Reset mid-stream, WAIT_STATES=3: after 3 grants assert reset_n for 1 cycle -> all outputs 0 immediately, no valid afterwards, oc=0; a new fetch after release completes normally.
